// File: rtl/matmul_host_seq.sv
// matmul_host_seq
//   Host-side sequencer for a 2x2 matrix multiplier with 2-bit elements.
//   Each frame collects eight operand elements from a valid/ready stream
//   (a11,a12,a21,a22,b11,b12,b21,b22), fires the multiplier for one cycle,
//   captures its 4-bit results, and then streams c11,c12,c21,c22 out.
//
//   Optional feature (define MATMUL_HOST_RANGE_CHECK_EN):
//     an element value of 3 is treated as out of range; the frame reports
//     err=1 and drains four zero results instead of the multiplier output.
//     Without the macro, err is tied low and results pass through unchanged.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand element offered
//   in_ready   block accepts element (only while loading)
//   in_data    2-bit operand element
//   mm_a       packed A: a11[1:0] a12[3:2] a21[5:4] a22[7:6]
//   mm_b       packed B, same layout
//   mm_en      one-cycle multiplier enable
//   mm_c_lo    c11[3:0] c12[7:4]
//   mm_c_hi    c21[3:0] c22[7:4]
//   out_valid  result element offered
//   out_ready  sink accepts element
//   out_data   4-bit result element
//   out_last   marks c22, the final element of the frame
//   err        current frame contained an out-of-range element
//
// state  | meaning
// LOAD   | accept 8 operand elements into mm_a/mm_b
// ISSUE  | single cycle, mm_en high
// CAPT   | single cycle, register mm_c_lo/mm_c_hi into the result buffer
// DRAIN  | stream the four results, advance on out_valid & out_ready

module matmul_host_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_data,
  output logic [7:0] mm_a,
  output logic [7:0] mm_b,
  output logic       mm_en,
  input  logic [7:0] mm_c_lo,
  input  logic [7:0] mm_c_hi,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_last,
  output logic       err
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state;
  logic [2:0]  load_cnt;
  logic [1:0]  out_idx;
  logic [15:0] result;
  logic        in_fire;
  logic        out_fire;
  logic        frame_bad;

  assign in_ready  = (state == ST_LOAD);
  assign mm_en     = (state == ST_ISSUE);
  assign out_valid = (state == ST_DRAIN);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_last  = out_valid & (out_idx == 2'd3);

`ifdef MATMUL_HOST_RANGE_CHECK_EN
  logic err_q;
  logic elem_bad;

  assign elem_bad = (in_data == 2'd3);

  // The first transfer of a frame restarts the flag, so a stale error from
  // the previous frame stays visible until new data actually arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (in_fire) begin
      if (load_cnt == 3'd0) err_q <= elem_bad;
      else                  err_q <= err_q | elem_bad;
    end
  end

  assign err       = err_q;
  assign frame_bad = err_q;
`else
  assign err       = 1'b0;
  assign frame_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_LOAD;
      load_cnt <= 3'd0;
      out_idx  <= 2'd0;
      result   <= 16'd0;
      mm_a     <= 8'd0;
      mm_b     <= 8'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            // Counter bit 2 selects the B matrix; bits 1:0 pick the slot.
            if (!load_cnt[2]) mm_a[{load_cnt[1:0], 1'b0} +: 2] <= in_data;
            else              mm_b[{load_cnt[1:0], 1'b0} +: 2] <= in_data;
            load_cnt <= load_cnt + 3'd1;
            if (load_cnt == 3'd7) state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          result  <= frame_bad ? 16'd0 : {mm_c_hi, mm_c_lo};
          out_idx <= 2'd0;
          state   <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_fire) begin
            out_idx <= out_idx + 2'd1;
            if (out_idx == 2'd3) state <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Result buffer is {c22, c21, c12, c11}; index order matches the stream.
  always_comb begin
    out_data = 4'd0;
    if (out_valid) begin
      case (out_idx)
        2'd0:    out_data = result[3:0];
        2'd1:    out_data = result[7:4];
        2'd2:    out_data = result[11:8];
        default: out_data = result[15:12];
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_host_seq.sv
module tb_matmul_host_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic [7:0] mm_a;
  logic [7:0] mm_b;
  logic       mm_en;
  logic [7:0] mm_c_lo;
  logic [7:0] mm_c_hi;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       err;

  int checks = 0;
  int passes = 0;
  int en_total = 0;

`ifdef MATMUL_HOST_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  matmul_host_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mm_a(mm_a), .mm_b(mm_b), .mm_en(mm_en),
    .mm_c_lo(mm_c_lo), .mm_c_hi(mm_c_hi),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mm_en === 1'b1) en_total++;

  // Multiplier model: 2x2 product of the packed operands, 4-bit results.
  function automatic logic [3:0] mult_c(input logic [7:0] a, input logic [7:0] b, input int k);
    int i, j, s;
    i = k / 2;
    j = k % 2;
    s = int'(a[(2*i)*2 +: 2]) * int'(b[j*2 +: 2]) + int'(a[(2*i+1)*2 +: 2]) * int'(b[(2+j)*2 +: 2]);
    return 4'(s);
  endfunction

  always_comb begin
    mm_c_lo = {mult_c(mm_a, mm_b, 1), mult_c(mm_a, mm_b, 0)};
    mm_c_hi = {mult_c(mm_a, mm_b, 3), mult_c(mm_a, mm_b, 2)};
  end

  // Reference: frame element n (order a11,a12,a21,a22,b11,b12,b21,b22)
  function automatic int elem(input logic [15:0] f, input int n);
    return int'(f[2*n +: 2]);
  endfunction

  function automatic bit frame_has3(input logic [15:0] f);
    bit h = 1'b0;
    for (int n = 0; n < 8; n++) if (elem(f, n) == 3) h = 1'b1;
    return h;
  endfunction

  function automatic int ref_c(input logic [15:0] f, input int k);
    int a [2][2];
    int b [2][2];
    int s;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        a[r][c] = elem(f, 2*r + c);
        b[r][c] = elem(f, 4 + 2*r + c);
      end
    s = a[k/2][0] * b[0][k%2] + a[k/2][1] * b[1][k%2];
    if (RC && frame_has3(f)) return 0;
    return s % 16;
  endfunction

  function automatic int pack(input logic [15:0] f, input int base);
    return elem(f, base) + 4 * elem(f, base + 1) + 16 * elem(f, base + 2) + 64 * elem(f, base + 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] f, input bit gaps);
    bit acc;
    int budget;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          in_data  = 2'($urandom);
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = f[2*i +: 2];
      budget   = 0;
      do begin
        acc = in_ready;
        step();
        budget++;
      end while (!acc && budget < 20);
      if (!acc) begin
        checks++;
        $error("FAIL in_accept_timeout: observed no transfer expected transfer of element %0d", i);
      end
    end
    in_valid = 1'b0;
  endtask

  // Called right after the eighth transfer edge.
  task automatic post_issue(input logic [15:0] f);
    chk("issue_mm_en", mm_en, 1);
    chk("issue_in_ready", in_ready, 0);
    chk("issue_out_valid", out_valid, 0);
    chk("issue_mm_a", mm_a, pack(f, 0));
    chk("issue_mm_b", mm_b, pack(f, 4));
    step();
    chk("capt_mm_en", mm_en, 0);
    chk("capt_out_valid", out_valid, 0);
    chk("capt_mm_a_hold", mm_a, pack(f, 0));
    step();
    chk("latency_out_valid", out_valid, 1);
  endtask

  task automatic drain(input logic [15:0] f, input bit bp, input int first);
    for (int k = first; k < 4; k++) begin
      out_ready = 1'b0;
      if (bp) begin
        repeat ($urandom_range(0, 3)) begin
          chk("hold_out_data", out_data, ref_c(f, k));
          chk("hold_out_last", out_last, (k == 3));
          chk("hold_in_ready", in_ready, 0);
          step();
        end
      end
      out_ready = 1'b1;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, ref_c(f, k));
      chk("out_last", out_last, (k == 3));
      chk("err", err, RC && frame_has3(f));
      step();
    end
    out_ready = 1'b0;
    chk("post_drain_in_ready", in_ready, 1);
    chk("post_drain_out_valid", out_valid, 0);
  endtask

  task automatic run_frame(input logic [15:0] f, input bit gaps, input bit bp);
    int en0;
    en0 = en_total;
    send_frame(f, gaps);
    post_issue(f);
    drain(f, bp, 0);
    chk("mm_en_pulses", en_total - en0, 1);
  endtask

  logic [15:0] f030;
  logic [15:0] f2s;
  logic [15:0] fbad;
  logic [15:0] fr;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 2'd0; out_ready = 1'b0;
    // a11,a12,a21,a22 = 1,2,0,1 ; b11,b12,b21,b22 = 2,0,1,1
    f030 = {2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
    f2s  = 16'hAAAA;
    fbad = {2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1};
    repeat (3) step();
    reset = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mm_en", mm_en, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);

    // Known example: A=[[1,2],[0,1]], B=[[2,0],[1,1]]
    send_frame(f030, 1'b0);
    chk("ex_mm_a_const", mm_a, 8'h49);
    chk("ex_mm_b_const", mm_b, 8'h52);
    post_issue(f030);
    chk("ex_c11_const", out_data, 4);
    drain(f030, 1'b0, 0);

    run_frame(f2s, 1'b0, 1'b0);

    // Backpressure: out_ready low for 3 cycles on the first element
    send_frame(f030, 1'b0);
    post_issue(f030);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("bp_out_data", out_data, 4);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      step();
    end
    drain(f030, 1'b0, 0);

    // Randomly gapped input valid
    run_frame(f030, 1'b1, 1'b0);

    // Out-of-range element, then a clean frame
    run_frame(fbad, 1'b0, 1'b0);
    run_frame(f030, 1'b0, 1'b0);

    // Reset in DRAIN after two outputs
    send_frame(f030, 1'b0);
    post_issue(f030);
    drain_two: for (int k = 0; k < 2; k++) begin
      out_ready = 1'b1;
      chk("pre_rst_out_data", out_data, ref_c(f030, k));
      step();
    end
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_mm_a", mm_a, 0);
    chk("mid_rst_err", err, 0);
    run_frame(f2s, 1'b0, 1'b0);

    // Randomized frames with gaps and backpressure
    for (int n = 0; n < 15; n++) begin
      fr = 16'($urandom);
      run_frame(fr, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
